// File: rtl/riscv_imm_enc_pkg.sv
// Shared types, format codes and range helper for the immediate encoder.
package riscv_imm_enc_pkg;

    localparam int XLEN          = 32;
    localparam int IMM_ENC_CNT_W = 16;

    localparam logic [2:0] SRC_IMM_I = 3'd0;
    localparam logic [2:0] SRC_IMM_S = 3'd1;
    localparam logic [2:0] SRC_IMM_B = 3'd2;
    localparam logic [2:0] SRC_IMM_U = 3'd3;
    localparam logic [2:0] SRC_IMM_J = 3'd4;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic [2:0]      src;
        logic            err;
    } chk_t;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(
        input logic [XLEN-1:0] v,
        input int              bits
    );
        logic [XLEN-1:0] hi;
        hi = ~((XLEN'(1) << (bits - 1)) - XLEN'(1));
        return ((v & hi) == '0) || ((v & hi) == hi);
    endfunction

endpackage

// File: rtl/riscv_imm_enc_if.sv
// Request/response handshake bundle for the immediate encoder.
interface riscv_imm_enc_if;
    import riscv_imm_enc_pkg::*;

    logic            i_valid;
    logic            o_ready;
    logic [31:0]     i_instr;
    logic [XLEN-1:0] i_imm;
    logic [2:0]      i_imm_src;
    logic            o_valid;
    logic            i_ready;
    logic [31:0]     o_instr;
    logic            o_err;

    modport master (
        output i_valid, i_instr, i_imm, i_imm_src, i_ready,
        input  o_ready, o_valid, o_instr, o_err
    );

    modport slave (
        input  i_valid, i_instr, i_imm, i_imm_src, i_ready,
        output o_ready, o_valid, o_instr, o_err
    );

endinterface

// File: rtl/riscv_imm_pack.sv
// Combinational immediate scatter: clears the format's field, ORs in imm bits.
module riscv_imm_pack
    import riscv_imm_enc_pkg::*;
(
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_imm,
    input  logic [2:0]      i_imm_src,
    output logic [31:0]     o_instr
);

    logic [31:0] mask;
    logic [31:0] field;

    always_comb begin
        mask  = '0;
        field = '0;
        case (i_imm_src)
            SRC_IMM_I: begin
                mask  = 32'hFFF0_0000;
                field = {i_imm[11:0], 20'b0};
            end
            SRC_IMM_S: begin
                mask  = 32'hFE00_0F80;
                field = {i_imm[11:5], 13'b0,
                         i_imm[4:0], 7'b0};
            end
            SRC_IMM_B: begin
                mask  = 32'hFE00_0F80;
                field = {i_imm[12], i_imm[10:5], 13'b0,
                         i_imm[4:1], i_imm[11], 7'b0};
            end
            SRC_IMM_U: begin
                mask  = 32'hFFFF_F000;
                field = {i_imm[31:12], 12'b0};
            end
            SRC_IMM_J: begin
                mask  = 32'hFFFF_F000;
                field = {i_imm[20], i_imm[10:1], i_imm[11],
                         i_imm[19:12], 12'b0};
            end
            default: begin
                mask  = '0;
                field = '0;
            end
        endcase
        o_instr = (i_instr & ~mask) | field;
    end

endmodule

// File: rtl/riscv_imm_enc.sv
// Two-stage immediate encoder: range check, then field pack, with
// valid/ready flow control and saturating result counters.
module riscv_imm_enc
    import riscv_imm_enc_pkg::*;
#(
    parameter int CNT_W = IMM_ENC_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    riscv_imm_enc_if.slave   bus,
    output logic [CNT_W-1:0] o_ok_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    chk_t             s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_instr_q, s2_instr_d;
    logic             s2_err_q, s2_err_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             s1_advance;
    logic             ready;
    logic             accept;
    logic             deliver;
    logic             chk_err;
    logic [31:0]      packed_instr;

    always_comb begin
        chk_err = 1'b1;
        case (bus.i_imm_src)
            SRC_IMM_I, SRC_IMM_S:
                chk_err = !fits_signed(bus.i_imm, 12);
            SRC_IMM_B:
                chk_err = !fits_signed(bus.i_imm, 13)
                          || bus.i_imm[0];
            SRC_IMM_J:
                chk_err = !fits_signed(bus.i_imm, 21)
                          || bus.i_imm[0];
            SRC_IMM_U:
                chk_err = |bus.i_imm[11:0];
            default:
                chk_err = 1'b1;
        endcase
    end

    riscv_imm_pack u_pack (
        .i_instr   (s1_q.instr),
        .i_imm     (s1_q.imm),
        .i_imm_src (s1_q.src),
        .o_instr   (packed_instr)
    );

    always_comb begin
        s1_advance = !s2_valid_q || bus.i_ready;
        ready      = !i_rst && (!s1_valid_q || s1_advance);
        accept     = bus.i_valid && ready;
        deliver    = s2_valid_q && bus.i_ready;

        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        ok_cnt_d   = ok_cnt_q;
        err_cnt_d  = err_cnt_q;

        // Stage 1 drains into stage 2 whenever stage 2 is free or emptying.
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            s1_valid_d = 1'b0;
            if (s1_valid_q) begin
                s2_instr_d = packed_instr;
                s2_err_d   = s1_q.err;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d.instr = bus.i_instr;
            s1_d.imm   = bus.i_imm;
            s1_d.src   = bus.i_imm_src;
            s1_d.err   = chk_err;
        end

        if (deliver) begin
            if (s2_err_q) begin
                if (!(&err_cnt_q))
                    err_cnt_d = err_cnt_q + CNT_W'(1);
            end else begin
                if (!(&ok_cnt_q))
                    ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            ok_cnt_q   <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            ok_cnt_q   <= ok_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.o_ready = ready;
    assign bus.o_valid = s2_valid_q;
    assign bus.o_instr = s2_instr_q;
    assign bus.o_err   = s2_err_q;
    assign o_ok_cnt    = ok_cnt_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_riscv_imm_enc.sv
// Scoreboarded bench for riscv_imm_enc: encodes, checks, round-trips
// through a decode-style extractor, and exercises flow control.
module tb_riscv_imm_enc;
    import riscv_imm_enc_pkg::*;

    typedef struct {
        logic [31:0] tmpl;
        logic [31:0] imm;
        logic [2:0]  src;
        logic [31:0] instr;
        logic        err;
        int          acc;
    } txn_t;

    logic        clk;
    logic        i_rst;
    logic [15:0] ok_cnt, err_cnt;
    logic [1:0]  sat_ok, sat_err;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    txn_t        rq[$];
    txn_t        sbq[$];

    riscv_imm_enc_if tb_if ();
    riscv_imm_enc_if sat_if ();

    assign sat_if.i_valid   = tb_if.i_valid;
    assign sat_if.i_instr   = tb_if.i_instr;
    assign sat_if.i_imm     = tb_if.i_imm;
    assign sat_if.i_imm_src = tb_if.i_imm_src;
    assign sat_if.i_ready   = tb_if.i_ready;

    riscv_imm_enc dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .bus       (tb_if),
        .o_ok_cnt  (ok_cnt),
        .o_err_cnt (err_cnt)
    );

    riscv_imm_enc #(.CNT_W(2)) dut_sat (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .bus       (sat_if),
        .o_ok_cnt  (sat_ok),
        .o_err_cnt (sat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] model_pack(
        input logic [31:0] t, input logic [31:0] imm,
        input logic [2:0] src);
        logic [31:0] r;
        r = t;
        case (src)
            SRC_IMM_I: r[31:20] = imm[11:0];
            SRC_IMM_S: begin
                r[31:25] = imm[11:5];
                r[11:7]  = imm[4:0];
            end
            SRC_IMM_B: begin
                r[31]    = imm[12];
                r[30:25] = imm[10:5];
                r[11:8]  = imm[4:1];
                r[7]     = imm[11];
            end
            SRC_IMM_U: r[31:12] = imm[31:12];
            SRC_IMM_J: begin
                r[31]    = imm[20];
                r[30:21] = imm[10:1];
                r[20]    = imm[11];
                r[19:12] = imm[19:12];
            end
            default: r = t;
        endcase
        return r;
    endfunction

    function automatic logic model_err(
        input logic [31:0] imm, input logic [2:0] src);
        case (src)
            SRC_IMM_I, SRC_IMM_S:
                return imm !== {{20{imm[11]}}, imm[11:0]};
            SRC_IMM_B:
                return (imm !== {{19{imm[12]}}, imm[12:0]}) || imm[0];
            SRC_IMM_J:
                return (imm !== {{11{imm[20]}}, imm[20:0]}) || imm[0];
            SRC_IMM_U:
                return imm[11:0] != 12'd0;
            default:
                return 1'b1;
        endcase
    endfunction

    // Decode-stage extractor, used to round-trip encoded results.
    function automatic logic [31:0] decode(
        input logic [31:0] i, input logic [2:0] src);
        case (src)
            SRC_IMM_I: return {{20{i[31]}}, i[31:20]};
            SRC_IMM_S: return {{20{i[31]}}, i[31:25], i[11:7]};
            SRC_IMM_B: return {{19{i[31]}}, i[31], i[7],
                               i[30:25], i[11:8], 1'b0};
            SRC_IMM_U: return {i[31:12], 12'b0};
            SRC_IMM_J: return {{11{i[31]}}, i[31], i[19:12],
                               i[20], i[30:21], 1'b0};
            default:   return 32'd0;
        endcase
    endfunction

    function automatic txn_t mk(
        input logic [31:0] tmpl, input logic [31:0] imm,
        input logic [2:0] src);
        txn_t t;
        t.tmpl  = tmpl;
        t.imm   = imm;
        t.src   = src;
        t.instr = model_pack(tmpl, imm, src);
        t.err   = model_err(imm, src);
        t.acc   = 0;
        return t;
    endfunction

    function automatic txn_t mkx(
        input logic [31:0] tmpl, input logic [31:0] imm,
        input logic [2:0] src, input logic [31:0] exp_instr,
        input logic exp_err);
        txn_t t;
        t.tmpl  = tmpl;
        t.imm   = imm;
        t.src   = src;
        t.instr = exp_instr;
        t.err   = exp_err;
        t.acc   = 0;
        return t;
    endfunction

    task automatic drive_head();
        if (rq.size() != 0) begin
            tb_if.i_valid   = 1'b1;
            tb_if.i_instr   = rq[0].tmpl;
            tb_if.i_imm     = rq[0].imm;
            tb_if.i_imm_src = rq[0].src;
        end else begin
            tb_if.i_valid   = 1'b0;
        end
    endtask

    task automatic test_reset();
        tb_if.i_valid   = 1'b0;
        tb_if.i_ready   = 1'b0;
        tb_if.i_instr   = '0;
        tb_if.i_imm     = '0;
        tb_if.i_imm_src = '0;
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tb_if.o_valid !== 1'b0 || tb_if.o_instr !== 32'd0
            || tb_if.o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_out got v=%b i=%h e=%b want 0/0/0",
                     tb_if.o_valid, tb_if.o_instr, tb_if.o_err);
        end
        n_cmp++;
        if (ok_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_cnt got %0d/%0d want 0/0", ok_cnt, err_cnt);
        end
        n_cmp++;
        if (tb_if.o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_ready got %b want 0", tb_if.o_ready);
        end
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if (tb_if.o_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL post_rst_ready got %b want 1", tb_if.o_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_formats();
        int got = 0;
        int lim = 0;
        txn_t e;
        rq.push_back(mkx(32'h0000_0093, 32'hFFFF_FFFF, SRC_IMM_I,
                         32'hFFF0_0093, 1'b0));
        rq.push_back(mkx(32'h0020_A023, 32'd8, SRC_IMM_S,
                         32'h0020_A423, 1'b0));
        rq.push_back(mkx(32'h0000_0063, 32'hFFFF_FFFC, SRC_IMM_B,
                         32'hFE00_0EE3, 1'b0));
        rq.push_back(mkx(32'h0000_02B7, 32'h1234_5000, SRC_IMM_U,
                         32'h1234_52B7, 1'b0));
        rq.push_back(mkx(32'h0000_006F, 32'h0000_0800, SRC_IMM_J,
                         32'h0010_006F, 1'b0));
        tb_if.i_ready = 1'b1;
        while (got < 5 && lim < 40) begin
            drive_head();
            #1;
            if (tb_if.o_valid && tb_if.i_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL fmt_extra got %h want none",
                             tb_if.o_instr);
                end else begin
                    e = sbq.pop_front();
                    if (tb_if.o_instr !== e.instr
                        || tb_if.o_err !== e.err) begin
                        n_bad++;
                        $display("FAIL fmt_data got %h/%b want %h/%b",
                                 tb_if.o_instr, tb_if.o_err,
                                 e.instr, e.err);
                    end
                    n_cmp++;
                    if (cyc - e.acc != 2) begin
                        n_bad++;
                        $display("FAIL fmt_latency got %0d want 2",
                                 cyc - e.acc);
                    end
                    n_cmp++;
                    if (decode(tb_if.o_instr, e.src) !== e.imm) begin
                        n_bad++;
                        $display("FAIL fmt_roundtrip got %h want %h",
                                 decode(tb_if.o_instr, e.src), e.imm);
                    end
                end
                got++;
            end
            if (tb_if.i_valid && tb_if.o_ready) begin
                e = rq.pop_front();
                e.acc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            lim++;
        end
        n_cmp++;
        if (got != 5) begin
            n_bad++;
            $display("FAIL fmt_timeout got %0d results want 5", got);
        end
        n_cmp++;
        if (ok_cnt !== 16'd5 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL fmt_cnt got %0d/%0d want 5/0", ok_cnt, err_cnt);
        end
    endtask

    task automatic test_saturation();
        n_cmp++;
        if (sat_ok !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_ok got %0d want 3", sat_ok);
        end
    endtask

    task automatic test_faults();
        int got = 0;
        int lim = 0;
        txn_t e;
        rq.push_back(mkx(32'h0000_0013, 32'd2048, SRC_IMM_I,
                         32'h8000_0013, 1'b1));
        rq.push_back(mkx(32'h0000_0063, 32'd3, SRC_IMM_B,
                         32'h0000_0163, 1'b1));
        rq.push_back(mkx(32'h1234_5678, 32'hDEAD_BEEF, 3'b111,
                         32'h1234_5678, 1'b1));
        tb_if.i_ready = 1'b1;
        while (got < 3 && lim < 30) begin
            drive_head();
            #1;
            if (tb_if.o_valid && tb_if.i_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL flt_extra got %h want none",
                             tb_if.o_instr);
                end else begin
                    e = sbq.pop_front();
                    if (tb_if.o_instr !== e.instr
                        || tb_if.o_err !== e.err) begin
                        n_bad++;
                        $display("FAIL flt_data got %h/%b want %h/%b",
                                 tb_if.o_instr, tb_if.o_err,
                                 e.instr, e.err);
                    end
                end
                got++;
            end
            if (tb_if.i_valid && tb_if.o_ready) begin
                e = rq.pop_front();
                e.acc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            lim++;
        end
        n_cmp++;
        if (got != 3) begin
            n_bad++;
            $display("FAIL flt_timeout got %0d results want 3", got);
        end
        n_cmp++;
        if (err_cnt !== 16'd3 || ok_cnt !== 16'd5) begin
            n_bad++;
            $display("FAIL flt_cnt got ok=%0d err=%0d want 5/3",
                     ok_cnt, err_cnt);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        int nacc = 0;
        int k = 0;
        txn_t e;
        rq.push_back(mk(32'h0000_0013, 32'd1, SRC_IMM_I));
        rq.push_back(mk(32'h0000_0113, 32'd2, SRC_IMM_I));
        rq.push_back(mk(32'h0000_0213, 32'd3, SRC_IMM_I));
        while (got < 3 && k < 30) begin
            drive_head();
            tb_if.i_ready = (k >= 4);
            #1;
            if (k == 2 || k == 3) begin
                n_cmp++;
                if (tb_if.o_ready !== 1'b0 || nacc != 2) begin
                    n_bad++;
                    $display("FAIL bp_ready got r=%b acc=%0d want 0/2",
                             tb_if.o_ready, nacc);
                end
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_hold got empty scoreboard want 2");
                end else if (tb_if.o_valid !== 1'b1
                             || tb_if.o_instr !== sbq[0].instr) begin
                    n_bad++;
                    $display("FAIL bp_hold got %b/%h want 1/%h",
                             tb_if.o_valid, tb_if.o_instr, sbq[0].instr);
                end
            end
            if (tb_if.o_valid && tb_if.i_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_extra got %h want none",
                             tb_if.o_instr);
                end else begin
                    e = sbq.pop_front();
                    if (tb_if.o_instr !== e.instr
                        || tb_if.o_err !== e.err) begin
                        n_bad++;
                        $display("FAIL bp_order got %h/%b want %h/%b",
                                 tb_if.o_instr, tb_if.o_err,
                                 e.instr, e.err);
                    end
                end
                got++;
            end
            if (tb_if.i_valid && tb_if.o_ready) begin
                e = rq.pop_front();
                e.acc = cyc;
                sbq.push_back(e);
                nacc++;
            end
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (got != 3) begin
            n_bad++;
            $display("FAIL bp_timeout got %0d results want 3", got);
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int lim = 0;
        logic [31:0] r, imm;
        txn_t e;
        for (int n = 0; n < 24; n++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0:       imm = r;
                1:       imm = {{20{r[11]}}, r[11:1], 1'b0};
                default: imm = {r[31:12], 12'b0};
            endcase
            rq.push_back(mk($urandom, imm, 3'($urandom_range(0, 4))));
        end
        while (got < 24 && lim < 300) begin
            drive_head();
            tb_if.i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (tb_if.o_valid && tb_if.i_ready) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL b2b_extra got %h want none",
                             tb_if.o_instr);
                end else begin
                    e = sbq.pop_front();
                    if (tb_if.o_instr !== e.instr
                        || tb_if.o_err !== e.err) begin
                        n_bad++;
                        $display("FAIL b2b_data got %h/%b want %h/%b",
                                 tb_if.o_instr, tb_if.o_err,
                                 e.instr, e.err);
                    end
                    if (!e.err) begin
                        n_cmp++;
                        if (decode(tb_if.o_instr, e.src) !== e.imm) begin
                            n_bad++;
                            $display("FAIL b2b_roundtrip got %h want %h",
                                     decode(tb_if.o_instr, e.src), e.imm);
                        end
                    end
                end
                got++;
            end
            if (tb_if.i_valid && tb_if.o_ready) begin
                e = rq.pop_front();
                e.acc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            lim++;
        end
        n_cmp++;
        if (got != 24) begin
            n_bad++;
            $display("FAIL b2b_timeout got %0d results want 24", got);
        end
        tb_if.i_valid = 1'b0;
    endtask

    task automatic test_reset_midflight();
        txn_t e;
        rq.push_back(mk(32'h0000_0013, 32'd7, SRC_IMM_I));
        rq.push_back(mk(32'h0000_0013, 32'd9, SRC_IMM_I));
        tb_if.i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_head();
            #1;
            if (tb_if.i_valid && tb_if.o_ready) begin
                e = rq.pop_front();
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        tb_if.i_valid = 1'b0;
        n_cmp++;
        if (tb_if.o_valid !== 1'b1 || sbq.size() != 2) begin
            n_bad++;
            $display("FAIL mid_fill got v=%b n=%0d want 1/2",
                     tb_if.o_valid, sbq.size());
        end
        i_rst = 1'b1;
        tb_if.i_ready = 1'b1;
        #1;
        n_cmp++;
        if (tb_if.o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_ready got %b want 0", tb_if.o_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (tb_if.o_valid !== 1'b0 || ok_cnt !== 16'd0
            || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_rst got v=%b ok=%0d err=%0d want 0/0/0",
                     tb_if.o_valid, ok_cnt, err_cnt);
        end
        i_rst = 1'b0;
        sbq.delete();
        rq.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (tb_if.o_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_stale got o_valid=%b want 0",
                         tb_if.o_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_saturation();
        test_faults();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
